// File: rtl/port_tx.sv
// port_tx: transmit side of the in_port/ready_in handshake.
// Bytes pushed by a producer are queued in a small FIFO. Each byte is driven
// onto in_port, held stable through a setup window, then a ready_in high pulse,
// then a low gap, so the receiver sees exactly one rising edge per byte.
// Optional feature macro: PORT_TX_ACK_EN adds ack_in. When it is defined, the
// ready_in pulse is stretched until the receiver acknowledges.
module port_tx #(
  parameter int BUS_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [BUS_WIDTH-1:0]               wr_data,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  output logic [BUS_WIDTH-1:0]               in_port,
  output logic                               ready_in,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
`ifdef PORT_TX_ACK_EN
  ,
  input  logic                               ack_in
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = $clog2(FIFO_DEPTH+1);
  localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ?
                           ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES) :
                           ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_d;
  logic                   pop;
  logic                   push;
  logic                   hold_done;

  logic [BUS_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;

  assign wr_ready = (count != OCC_W'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign busy     = (state_q != IDLE) || (count != '0);

`ifdef PORT_TX_ACK_EN
  // The pulse ends only once the minimum width has elapsed and the receiver acknowledges.
  assign hold_done = (cnt_q == '0) && ack_in;
`else
  assign hold_done = (cnt_q == '0);
`endif

  // Queue storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Queue pointers and occupancy; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Handshake state, shared down-counter, registered strobe and data outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_in <= 1'b0;
      in_port  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_in <= ready_d;
      if (pop) in_port <= mem[rd_ptr];
    end
  end

  // Next-state logic: IDLE loads a byte, then SETUP / HOLD / GAP count down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_in;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (count != '0) begin
          pop     = 1'b1;
          cnt_d   = CNT_W'(SETUP_CYCLES - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          ready_d = 1'b1;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (hold_done) begin
          ready_d = 1'b0;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_port_tx.sv
// Testbench for port_tx: timeline-based reference model, receiver model and
// directed vectors with literal expectations.
module tb_port_tx;
  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int SETUP = 2;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [BW-1:0] in_port;
  logic          ready_in;
  logic          busy;
  logic [CW-1:0] count;
`ifdef PORT_TX_ACK_EN
  logic          ack_in = 1'b0;
`endif

  port_tx #(.BUS_WIDTH(BW), .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP),
            .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .in_port(in_port), .ready_in(ready_in),
    .busy(busy), .count(count)
`ifdef PORT_TX_ACK_EN
    , .ack_in(ack_in)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending bytes plus the elapsed cycles since the current byte was loaded.
  logic [BW-1:0] mq[$];
  logic [BW-1:0] rxq[$];
  logic [BW-1:0] m_cur = '0;
  bit            m_act = 1'b0;
  int            m_e = 0;
  int            rx_caps = 0;
  logic [BW-1:0] s1 = '0, s2 = '0, rx_exp;
  logic          r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit full;
    if (reset) begin
      mq.delete(); rxq.delete();
      m_cur = '0; m_act = 1'b0; m_e = 0;
      s1 = '0; s2 = '0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
    end else begin
      full = (mq.size() == DEPTH);
      // receiver: two-flop data sampling, rising-edge detect on the synchronised strobe
      if (r2 && !r3) begin
        rx_caps++;
        if (rxq.size() == 0) chk("rx_unexpected_byte", 32'(s2), 32'hFFFF_FFFF);
        else begin
          rx_exp = rxq.pop_front();
          chk("rx_byte", 32'(s2), 32'(rx_exp));
        end
      end
      r3 = r2; r2 = r1; r1 = ready_in; s2 = s1; s1 = in_port;
      // transmitter timeline
      if (!m_act) begin
        if (mq.size() > 0) begin
          m_cur = mq.pop_front(); m_act = 1'b1; m_e = 0;
        end
      end else begin
`ifdef PORT_TX_ACK_EN
        if (!(m_e == SETUP+HOLD-1 && !ack_in)) m_e++;
`else
        m_e++;
`endif
        if (m_e == SETUP+HOLD+GAP) m_act = 1'b0;
      end
      if (wr_valid && !full) begin
        mq.push_back(wr_data);
        rxq.push_back(wr_data);
      end
    end
  end

  // Per-cycle comparison against the model, plus ready_in rising-edge bookkeeping.
  bit   cmp_en = 1'b0;
  bit   rise_chk = 1'b0;
  int   cyc = 0;
  int   last_rise = -1;
  int   rises = 0;
  logic prev_r = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      chk("m_in_port",  32'(in_port),  32'(m_cur));
      chk("m_ready_in", 32'(ready_in), 32'(m_act && m_e >= SETUP && m_e < SETUP+HOLD));
      chk("m_count",    32'(count),    32'(mq.size()));
      chk("m_wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
      chk("m_busy",     32'(busy),     32'(m_act || mq.size() > 0));
    end
    if (ready_in && !prev_r) begin
      rises++;
      if (rise_chk && last_rise >= 0) chk("rise_spacing", 32'(cyc - last_rise), 32'd9);
      last_rise = cyc;
    end
    prev_r = ready_in;
  end

  // Offer one byte from a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [BW-1:0] b);
    int n;
    n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  int r0, c0;

  initial begin
    // 1: reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_port",  32'(in_port),  32'h00);
    chk("rst_ready_in", 32'(ready_in), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    cmp_en = 1'b1;

    // 2: single byte, exact pulse timing relative to push edge k
    push(8'hA5);
    @(negedge clk);
    chk("t2_in_port_k1", 32'(in_port), 32'hA5);
    chk("t2_ready_k1",   32'(ready_in), 32'd0);
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk);
      chk($sformatf("t2_ready_k%0d", i), 32'(ready_in), 32'((i >= 3 && i <= 6) ? 1 : 0));
    end
    @(negedge clk);
    chk("t2_busy_k8", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t2_busy_k9", 32'(busy), 32'd0);
    chk("t2_in_port_hold", 32'(in_port), 32'hA5);

    // 3: back-to-back pushes, FIFO fills, in-order delivery 9 cycles apart
    r0 = rises;
    last_rise = -1;
    rise_chk = 1'b1;
    for (int b = 1; b <= 5; b++) push(8'(b));
    chk("t3_full_wr_ready", 32'(wr_ready), 32'd0);
    chk("t3_full_count",    32'(count),    32'd4);
    push(8'h06);
    wait_idle(300);
    rise_chk = 1'b0;
    chk("t3_rises", 32'(rises - r0), 32'd6);
    chk("t3_last_byte", 32'(in_port), 32'h06);

    // 4: reset during HOLD with three bytes queued
    for (int b = 0; b < 4; b++) push(8'h11 + 8'(b));
    chk("t4_pre_ready", 32'(ready_in), 32'd1);
    chk("t4_pre_count", 32'(count),    32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t4_async_ready", 32'(ready_in), 32'd0);
    chk("t4_async_count", 32'(count),    32'd0);
    chk("t4_async_busy",  32'(busy),     32'd0);
    chk("t4_async_port",  32'(in_port),  32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    r0 = rises;
    repeat (20) @(negedge clk);
    chk("t4_no_pulse", 32'(rises - r0), 32'd0);

    // 5: receiver captures a mix of patterns with idle gaps between pushes
    c0 = rx_caps;
    push(8'hFF);
    repeat (3) @(negedge clk);
    push(8'h00);
    push(8'h80);
    repeat (11) @(negedge clk);
    push(8'h7E);
    wait_idle(300);
    repeat (4) @(negedge clk);
    chk("t5_captures", 32'(rx_caps - c0), 32'd4);
    chk("t5_rx_drained", 32'(rxq.size()), 32'd0);

`ifdef PORT_TX_ACK_EN
    // 6: acknowledged handshake; ack during SETUP is ignored, pulse stretched until ack
    ack_in = 1'b1;
    push(8'h3C);
    repeat (3) @(negedge clk);
    chk("t6_ready_k3", 32'(ready_in), 32'd1);
    ack_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_ready_k13", 32'(ready_in), 32'd1);
    chk("t6_in_port",   32'(in_port),  32'h3C);
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    chk("t6_ready_k14", 32'(ready_in), 32'd0);
    wait_idle(100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
